fwd_regfile: RTL and testbench

Parametrised register file with built-in operand forwarding and load-use hazard detection for the phase-sequenced pipelined CPU. It is the successor to the fixed 8x16 regfile plus per-operand forwarding muxes. It has generic width and depth, and forwards on both source operands. Forwarding is per-register and compares the real source select, replacing the select-only compare. It adds a stall output, flush, and a saturating stall counter. It sits between the decode stage (IR) and the ALU/dmem stage, and is written from the write-back stage.

---
 rtl/fwd_regfile_pkg.sv | 40 ++++
 rtl/fwd_regfile_if.sv | 50 +++++
 rtl/fwd_regfile_fwd_mux.sv | 43 ++++
 rtl/fwd_regfile.sv | 132 +++++++++++++
 tb/tb_fwd_regfile.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_regfile_pkg.sv
// fwd_regfile_pkg: shared types, default sizes and the forwarding priority
// function used by the forwarding register file and its operand muxes.
// Optional build macro ZERO_REG_EN (hard-wired zero register) is handled
// in fwd_mux and fwd_regfile; nothing here depends on it.
package fwd_regfile_pkg;

   // Default geometry; the modules take these as parameter defaults.
   localparam int DEF_DATA_W = 16;
   localparam int DEF_SEL_W  = 3;
   localparam int DEF_CNT_W  = 8;

   // Number of architectural registers for the default select width.
   localparam int NREG = 2 ** DEF_SEL_W;

   // Widest operand the forwarding function is able to carry; wider
   // DATA_W values would be truncated by fwd_pick.
   localparam int MAX_DATA_W = 64;

   typedef logic [DEF_SEL_W-1:0]  sel_t;
   typedef logic [MAX_DATA_W-1:0] word_t;

   // Forwarding priority: the execute-stage result is the youngest value,
   // then the write-back value, then whatever sits in the array.
   function automatic word_t fwd_pick(input logic  ex_hit,
                                      input logic  wb_hit,
                                      input word_t ex_d,
                                      input word_t wb_d,
                                      input word_t arr_d);
      word_t res;
      if (ex_hit) begin
         res = ex_d;
      end else if (wb_hit) begin
         res = wb_d;
      end else begin
         res = arr_d;
      end
      return res;
   endfunction

endpackage

// File: rtl/fwd_regfile_if.sv
// fwd_regfile_if: pipeline-side bus of the forwarding register file.
// Groups the decode read port, the execute-stage forwarding inputs, the
// write-back port, flush and the hazard outputs. The master modport is the
// pipeline control; the slave modport is the register file.
interface fwd_regfile_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 8
);

   // Decode-stage operand request and registered operands
   logic              rd_load;
   logic [SEL_W-1:0]  rsel_a;
   logic [SEL_W-1:0]  rsel_b;
   logic [DATA_W-1:0] q_a;
   logic [DATA_W-1:0] q_b;

   // Execute-stage destination and result
   logic              ex_valid;
   logic [SEL_W-1:0]  ex_sel;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_d;

   // Write-back port
   logic              wb_load;
   logic [SEL_W-1:0]  wb_sel;
   logic [DATA_W-1:0] wb_d;

   // Control and hazard reporting
   logic              flush;
   logic              stall;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output rd_load, rsel_a, rsel_b,
      output ex_valid, ex_sel, ex_ready, ex_d,
      output wb_load, wb_sel, wb_d,
      output flush,
      input  q_a, q_b, stall, stall_cnt
   );

   modport slave (
      input  rd_load, rsel_a, rsel_b,
      input  ex_valid, ex_sel, ex_ready, ex_d,
      input  wb_load, wb_sel, wb_d,
      input  flush,
      output q_a, q_b, stall, stall_cnt
   );

endinterface

// File: rtl/fwd_regfile_fwd_mux.sv
// fwd_mux: combinational forwarding mux for one source operand.
// Compares the real source select against the execute and write-back
// destinations and picks the youngest value.
// Build macro ZERO_REG_EN: select 0 never forwards and always reads 0.
module fwd_mux
   import fwd_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic [SEL_W-1:0]              sel,
   input  logic                          ex_valid,
   input  logic                          ex_ready,
   input  logic [SEL_W-1:0]              ex_sel,
   input  logic [DATA_W-1:0]             ex_d,
   input  logic                          wb_load,
   input  logic [SEL_W-1:0]              wb_sel,
   input  logic [DATA_W-1:0]             wb_d,
   input  logic [(2**SEL_W)*DATA_W-1:0]  regs_flat,
   output logic [DATA_W-1:0]             fwd
);

   logic              ex_hit;
   logic              wb_hit;
   logic [DATA_W-1:0] arr_d;

   // Match detection and final pick; only a completed execute result may forward
   always_comb begin
      ex_hit = ex_valid & ex_ready & (ex_sel == sel);
      wb_hit = wb_load & (wb_sel == sel);
      arr_d  = regs_flat[sel*DATA_W +: DATA_W];
`ifdef ZERO_REG_EN
      if (sel == '0) begin
         ex_hit = 1'b0;
         wb_hit = 1'b0;
         arr_d  = '0;
      end
`endif
      fwd = DATA_W'(fwd_pick(ex_hit, wb_hit, word_t'(ex_d), word_t'(wb_d),
                             word_t'(arr_d)));
   end

endmodule

// File: rtl/fwd_regfile.sv
// fwd_regfile: parametrised register file with operand forwarding on both
// sources, load-use stall detection, flush and a saturating stall counter.
// Sits between decode and ALU/dmem; written from write-back.
// Build macro ZERO_REG_EN: register 0 is hard-wired to zero, ignores writes,
// never forwards and never causes a stall.
module fwd_regfile
   import fwd_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W,
   parameter int CNT_W  = DEF_CNT_W,
   localparam int NREG_L = 2 ** SEL_W
) (
   input  logic                     CLK,
   input  logic                     RSTN,
   fwd_regfile_if.slave             bus,
   output logic [NREG_L*DATA_W-1:0] dbg_regs
);

   logic [NREG_L-1:0][DATA_W-1:0] regs_q;
   logic [NREG_L-1:0][DATA_W-1:0] regs_d;
   logic [DATA_W-1:0]             q_a_q;
   logic [DATA_W-1:0]             q_a_d;
   logic [DATA_W-1:0]             q_b_q;
   logic [DATA_W-1:0]             q_b_d;
   logic [CNT_W-1:0]              stall_cnt_q;
   logic [CNT_W-1:0]              stall_cnt_d;
   logic [DATA_W-1:0]             fwd_a;
   logic [DATA_W-1:0]             fwd_b;
   logic                          hit_a;
   logic                          hit_b;
   logic                          stall_w;

   fwd_mux #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_fwd_a (
      .sel       (bus.rsel_a),
      .ex_valid  (bus.ex_valid),
      .ex_ready  (bus.ex_ready),
      .ex_sel    (bus.ex_sel),
      .ex_d      (bus.ex_d),
      .wb_load   (bus.wb_load),
      .wb_sel    (bus.wb_sel),
      .wb_d      (bus.wb_d),
      .regs_flat (regs_q),
      .fwd       (fwd_a)
   );

   fwd_mux #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_fwd_b (
      .sel       (bus.rsel_b),
      .ex_valid  (bus.ex_valid),
      .ex_ready  (bus.ex_ready),
      .ex_sel    (bus.ex_sel),
      .ex_d      (bus.ex_d),
      .wb_load   (bus.wb_load),
      .wb_sel    (bus.wb_sel),
      .wb_d      (bus.wb_d),
      .regs_flat (regs_q),
      .fwd       (fwd_b)
   );

   // Load-use hazard: an unfinished load in execute targets one of the sources
   always_comb begin
      hit_a = (bus.ex_sel == bus.rsel_a);
      hit_b = (bus.ex_sel == bus.rsel_b);
`ifdef ZERO_REG_EN
      if (bus.ex_sel == '0) begin
         hit_a = 1'b0;
         hit_b = 1'b0;
      end
`endif
      stall_w = bus.rd_load & bus.ex_valid & ~bus.ex_ready & (hit_a | hit_b);
   end

   // Write-back into the array; one write per cycle
   always_comb begin
      regs_d = regs_q;
      if (bus.wb_load) begin
         regs_d[bus.wb_sel] = bus.wb_d;
      end
`ifdef ZERO_REG_EN
      regs_d[0] = '0;
`endif
   end

   // Operand latch: flush squashes, a clean decode strobe loads, otherwise hold
   always_comb begin
      q_a_d = q_a_q;
      q_b_d = q_b_q;
      if (bus.flush) begin
         q_a_d = '0;
         q_b_d = '0;
      end else if (bus.rd_load && !stall_w) begin
         q_a_d = fwd_a;
         q_b_d = fwd_b;
      end
   end

   // Stall counter counts unflushed stall edges and sticks at all-ones
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_w && !bus.flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         regs_q      <= '0;
         q_a_q       <= '0;
         q_b_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         regs_q      <= regs_d;
         q_a_q       <= q_a_d;
         q_b_q       <= q_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.q_a       = q_a_q;
   assign bus.q_b       = q_b_q;
   assign bus.stall     = stall_w;
   assign bus.stall_cnt = stall_cnt_q;
   assign dbg_regs      = regs_q;

endmodule

// File: tb/tb_fwd_regfile.sv
// tb_fwd_regfile: directed self-checking bench for fwd_regfile, built with
// CNT_W=2 so counter saturation is reachable. Exercises the ZERO_REG_EN
// behaviour when that macro is defined, the ordinary register 0 otherwise.
module tb_fwd_regfile;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 2;
   localparam int NREG   = 2 ** SEL_W;

   logic                   CLK;
   logic                   RSTN;
   logic [NREG*DATA_W-1:0] dbg_regs;
   int                     checks;
   int                     errors;

   fwd_regfile_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   fwd_regfile #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .bus      (bus),
      .dbg_regs (dbg_regs)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic idle();
      bus.rd_load  = 1'b0;
      bus.rsel_a   = '0;
      bus.rsel_b   = '0;
      bus.ex_valid = 1'b0;
      bus.ex_sel   = '0;
      bus.ex_ready = 1'b0;
      bus.ex_d     = '0;
      bus.wb_load  = 1'b0;
      bus.wb_sel   = '0;
      bus.wb_d     = '0;
      bus.flush    = 1'b0;
   endtask

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (bus.q_a !== 16'h0) begin errors++; $display("[TB] FAIL reset_q_a: got %h expected 0000", bus.q_a); end
      checks++; if (bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL reset_q_b: got %h expected 0000", bus.q_b); end
      checks++; if (bus.stall_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.stall_cnt); end
      checks++; if (dbg_regs !== '0) begin errors++; $display("[TB] FAIL reset_regs: got %h expected 0", dbg_regs); end
      // write reg3, latch it, build a stall count, then reset between edges
      idle(); bus.wb_load = 1'b1; bus.wb_sel = 3'd3; bus.wb_d = 16'h1234; step();
      checks++; if (dbg_regs[3*DATA_W +: DATA_W] !== 16'h1234) begin errors++; $display("[TB] FAIL write_reg3: got %h expected 1234", dbg_regs[3*DATA_W +: DATA_W]); end
      idle(); bus.rd_load = 1'b1; bus.rsel_a = 3'd3; bus.rsel_b = 3'd3; step();
      checks++; if (bus.q_a !== 16'h1234) begin errors++; $display("[TB] FAIL read_reg3: got %h expected 1234", bus.q_a); end
      idle(); bus.rd_load = 1'b1; bus.rsel_a = 3'd6; bus.ex_valid = 1'b1; bus.ex_sel = 3'd6; step();
      checks++; if (bus.stall_cnt !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset_cnt: got %0d expected 1", bus.stall_cnt); end
      #2 RSTN = 1'b0;
      #1;
      checks++; if (dbg_regs !== '0) begin errors++; $display("[TB] FAIL async_reset_regs: got %h expected 0", dbg_regs); end
      checks++; if (bus.q_a !== 16'h0 || bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL async_reset_q: got %h/%h expected 0000/0000", bus.q_a, bus.q_b); end
      checks++; if (bus.stall_cnt !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_cnt: got %0d expected 0", bus.stall_cnt); end
      idle();
      #1 RSTN = 1'b1;
   endtask

   task automatic test_wb_bypass();
      idle(); bus.wb_load = 1'b1; bus.wb_sel = 3'd2; bus.wb_d = 16'h00AA;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd2; bus.rsel_b = 3'd3; step();
      checks++; if (bus.q_a !== 16'h00AA) begin errors++; $display("[TB] FAIL wb_bypass_q_a: got %h expected 00aa", bus.q_a); end
      checks++; if (bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL wb_bypass_q_b: got %h expected 0000", bus.q_b); end
      checks++; if (dbg_regs[2*DATA_W +: DATA_W] !== 16'h00AA) begin errors++; $display("[TB] FAIL wb_bypass_reg2: got %h expected 00aa", dbg_regs[2*DATA_W +: DATA_W]); end
   endtask

   task automatic test_ex_priority();
      idle(); bus.ex_valid = 1'b1; bus.ex_ready = 1'b1; bus.ex_sel = 3'd5; bus.ex_d = 16'h0F0F;
      bus.wb_load = 1'b1; bus.wb_sel = 3'd5; bus.wb_d = 16'h1111;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd2; bus.rsel_b = 3'd5; step();
      checks++; if (bus.q_b !== 16'h0F0F) begin errors++; $display("[TB] FAIL ex_over_wb: got %h expected 0f0f", bus.q_b); end
      checks++; if (bus.q_a !== 16'h00AA) begin errors++; $display("[TB] FAIL ex_prio_q_a: got %h expected 00aa", bus.q_a); end
      checks++; if (dbg_regs[5*DATA_W +: DATA_W] !== 16'h1111) begin errors++; $display("[TB] FAIL ex_prio_reg5: got %h expected 1111", dbg_regs[5*DATA_W +: DATA_W]); end
      // distinct EX and WB destinations on the two operands
      idle(); bus.ex_valid = 1'b1; bus.ex_ready = 1'b1; bus.ex_sel = 3'd6; bus.ex_d = 16'h3333;
      bus.wb_load = 1'b1; bus.wb_sel = 3'd5; bus.wb_d = 16'h2222;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd5; bus.rsel_b = 3'd6; step();
      checks++; if (bus.q_a !== 16'h2222 || bus.q_b !== 16'h3333) begin errors++; $display("[TB] FAIL split_fwd: got %h/%h expected 2222/3333", bus.q_a, bus.q_b); end
      // an invalid execute slot must not forward
      idle(); bus.ex_valid = 1'b0; bus.ex_ready = 1'b1; bus.ex_sel = 3'd5; bus.ex_d = 16'hBEEF;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd5; bus.rsel_b = 3'd6; step();
      checks++; if (bus.q_a !== 16'h2222) begin errors++; $display("[TB] FAIL ex_invalid_no_fwd: got %h expected 2222", bus.q_a); end
      checks++; if (bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL reg6_unwritten: got %h expected 0000", bus.q_b); end
   endtask

   task automatic test_load_use();
      idle(); bus.rd_load = 1'b1; bus.rsel_a = 3'd2; bus.rsel_b = 3'd2; step();
      idle(); bus.ex_valid = 1'b1; bus.ex_ready = 1'b0; bus.ex_sel = 3'd4; bus.ex_d = 16'h9999;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd4; bus.rsel_b = 3'd1; #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_a: got %b expected 1", bus.stall); end
      step();
      checks++; if (bus.q_a !== 16'h00AA) begin errors++; $display("[TB] FAIL stall_hold_q_a: got %h expected 00aa", bus.q_a); end
      checks++; if (bus.stall_cnt !== 2'd1) begin errors++; $display("[TB] FAIL stall_cnt_1: got %0d expected 1", bus.stall_cnt); end
      bus.ex_ready = 1'b1; bus.ex_d = 16'h0042; #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got %b expected 0", bus.stall); end
      step();
      checks++; if (bus.q_a !== 16'h0042 || bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL load_resolved: got %h/%h expected 0042/0000", bus.q_a, bus.q_b); end
      // hazard on operand B
      bus.ex_ready = 1'b0; bus.rsel_a = 3'd1; bus.rsel_b = 3'd4; #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_b: got %b expected 1", bus.stall); end
      step();
      checks++; if (bus.stall_cnt !== 2'd2) begin errors++; $display("[TB] FAIL stall_cnt_2: got %0d expected 2", bus.stall_cnt); end
      // no decode strobe, no stall
      bus.rd_load = 1'b0; #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_rd: got %b expected 0", bus.stall); end
   endtask

   task automatic test_flush();
      idle(); bus.rd_load = 1'b1; bus.rsel_a = 3'd2; bus.rsel_b = 3'd5; step();
      checks++; if (bus.q_a !== 16'h00AA || bus.q_b !== 16'h2222) begin errors++; $display("[TB] FAIL pre_flush: got %h/%h expected 00aa/2222", bus.q_a, bus.q_b); end
      bus.ex_valid = 1'b1; bus.ex_ready = 1'b0; bus.ex_sel = 3'd4; bus.rsel_a = 3'd4; bus.flush = 1'b1; step();
      checks++; if (bus.q_a !== 16'h0 || bus.q_b !== 16'h0) begin errors++; $display("[TB] FAIL flush_q: got %h/%h expected 0000/0000", bus.q_a, bus.q_b); end
      checks++; if (bus.stall_cnt !== 2'd2) begin errors++; $display("[TB] FAIL flush_cnt: got %0d expected 2", bus.stall_cnt); end
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      idle();
      #2 RSTN = 1'b0;
      #1 RSTN = 1'b1;
      bus.ex_valid = 1'b1; bus.ex_ready = 1'b0; bus.ex_sel = 3'd7; bus.rd_load = 1'b1; bus.rsel_b = 3'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.stall_cnt !== exp_cnt[i]) begin errors++; $display("[TB] FAIL sat_cnt_%0d: got %0d expected %0d", i, bus.stall_cnt, exp_cnt[i]); end
      end
   endtask

   task automatic test_back_to_back();
      idle(); bus.wb_load = 1'b1; bus.wb_sel = 3'd1; bus.wb_d = 16'h0101;
      bus.rd_load = 1'b1; bus.rsel_a = 3'd1; step();
      checks++; if (bus.q_a !== 16'h0101) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 0101", bus.q_a); end
      bus.wb_sel = 3'd2; bus.wb_d = 16'h0202; bus.rsel_a = 3'd2; bus.rsel_b = 3'd1; step();
      checks++; if (bus.q_a !== 16'h0202 || bus.q_b !== 16'h0101) begin errors++; $display("[TB] FAIL b2b_second: got %h/%h expected 0202/0101", bus.q_a, bus.q_b); end
   endtask

   task automatic test_zero_reg();
      idle(); bus.wb_load = 1'b1; bus.wb_sel = 3'd0; bus.wb_d = 16'hFFFF; step();
      bus.rd_load = 1'b1; bus.rsel_a = 3'd0; bus.rsel_b = 3'd1; step();
`ifdef ZERO_REG_EN
      checks++; if (dbg_regs[DATA_W-1:0] !== 16'h0) begin errors++; $display("[TB] FAIL zero_reg_write: got %h expected 0000", dbg_regs[DATA_W-1:0]); end
      checks++; if (bus.q_a !== 16'h0) begin errors++; $display("[TB] FAIL zero_reg_read: got %h expected 0000", bus.q_a); end
      idle(); bus.ex_valid = 1'b1; bus.ex_ready = 1'b0; bus.ex_sel = 3'd0; bus.rd_load = 1'b1; bus.rsel_a = 3'd0; #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL zero_reg_stall: got %b expected 0", bus.stall); end
`else
      checks++; if (dbg_regs[DATA_W-1:0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL reg0_write: got %h expected ffff", dbg_regs[DATA_W-1:0]); end
      checks++; if (bus.q_a !== 16'hFFFF) begin errors++; $display("[TB] FAIL reg0_read: got %h expected ffff", bus.q_a); end
      idle(); bus.ex_valid = 1'b1; bus.ex_ready = 1'b0; bus.ex_sel = 3'd0; bus.rd_load = 1'b1; bus.rsel_a = 3'd0; #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL reg0_stall: got %b expected 1", bus.stall); end
`endif
      step();
      idle();
   endtask

   // Test sequence
   initial begin
      checks = 0;
      errors = 0;
      idle();
      RSTN = 1'b0;
      #12 RSTN = 1'b1;
      @(negedge CLK);
      test_reset();
      test_wb_bypass();
      test_ex_priority();
      test_load_use();
      test_flush();
      test_saturation();
      test_back_to_back();
      test_zero_reg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
